// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and BCD arithmetic helpers for the multi-slot alarm block.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
  } hhmm_t;

  localparam logic       FLD_HOUR = 1'b0;
  localparam logic       FLD_MIN  = 1'b1;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] RST_HOUR = 8'h01;
  localparam logic [7:0] RST_MIN  = 8'h00;

  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec_wrap(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00) return lim;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  // HH:MM + n minutes, wrapping at midnight; done in binary minutes-of-day.
  function automatic hhmm_t bcd_add_minutes(input logic [7:0] hh, input logic [7:0] mm,
                                            input logic [5:0] n);
    logic [10:0] t;
    logic [4:0]  h;
    logic [5:0]  m;
    hhmm_t       r;
    t = 11'(hh[7:4]) * 11'd600 + 11'(hh[3:0]) * 11'd60
      + 11'(mm[7:4]) * 11'd10 + 11'(mm[3:0]) + 11'(n);
    if (t >= 11'd1440) t = t - 11'd1440;
    h = 5'(t / 11'd60);
    m = 6'(t % 11'd60);
    r.hh = {4'(h / 5'd10), 4'(h % 5'd10)};
    r.mm = {4'(m / 6'd10), 4'(m % 6'd10)};
    return r;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser plus rising-edge detect: one press pulse per key assertion.
module key_edge (
  input  logic CLK,
  input  logic RSTN,
  input  logic key,
  output logic press_c
);

  logic [2:0] sh;

  always_ff @(posedge CLK) begin
    if (!RSTN) sh <= '0;
    else       sh <= {sh[1:0], key};
  end

  assign press_c = sh[1] & ~sh[2];

endmodule

// File: rtl/multi_alarm.sv
// NUM_ALARMS HH:MM alarms with shared edit keys, snooze with retry limit,
// ring auto-timeout and lowest-index-wins priority.
module multi_alarm
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 1,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          SET_MODE,
  input  logic [$clog2(NUM_ALARMS)-1:0] SEL,
  input  logic                          KEY_NEXT,
  input  logic                          KEY_UP,
  input  logic                          KEY_DOWN,
  input  logic                          KEY_EN,
  input  logic                          KEY_SNOOZE,
  input  logic [3:0]                    HOUR1,
  input  logic [3:0]                    HOUR0,
  input  logic [3:0]                    MIN1,
  input  logic [3:0]                    MIN0,
  input  logic [3:0]                    SEC1,
  input  logic [3:0]                    SEC0,
  output logic [3:0]                    AHOUR1,
  output logic [3:0]                    AHOUR0,
  output logic [3:0]                    AMIN1,
  output logic [3:0]                    AMIN0,
  output logic [NUM_ALARMS-1:0]         EN_MASK,
  output logic                          FIELD,
  output logic                          RING,
  output logic [$clog2(NUM_ALARMS)-1:0] RING_ID,
  output logic                          SNOOZED
);

  localparam int unsigned ID_W = $clog2(NUM_ALARMS);

  logic [7:0]            a_hour [NUM_ALARMS];
  logic [7:0]            a_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_mask;
  logic                  field;
  state_t                state;
  logic                  ring_q, snz_q;
  logic [ID_W-1:0]       ring_id;
  logic [3:0]            snz_cnt, ring_cnt;
  hhmm_t                 tgt;
  logic [7:0]            sec_q;
  logic                  p_next, p_up, p_down, p_en, p_snz;
  logic                  tick, match_any, hit, sel_ok;
  logic [ID_W-1:0]       hit_id;
  logic [7:0]            cur_hour, cur_min, cur_sec;

  key_edge u_k_next (.CLK(CLK), .RSTN(RSTN), .key(KEY_NEXT),   .press_c(p_next));
  key_edge u_k_up   (.CLK(CLK), .RSTN(RSTN), .key(KEY_UP),     .press_c(p_up));
  key_edge u_k_down (.CLK(CLK), .RSTN(RSTN), .key(KEY_DOWN),   .press_c(p_down));
  key_edge u_k_en   (.CLK(CLK), .RSTN(RSTN), .key(KEY_EN),     .press_c(p_en));
  key_edge u_k_snz  (.CLK(CLK), .RSTN(RSTN), .key(KEY_SNOOZE), .press_c(p_snz));

  assign cur_hour = {HOUR1, HOUR0};
  assign cur_min  = {MIN1, MIN0};
  assign cur_sec  = {SEC1, SEC0};
  assign sel_ok   = 32'(SEL) < NUM_ALARMS;

  // Seconds falling to :00 marks the single tick of each minute.
  assign tick = (cur_sec == 8'h00) && (sec_q != 8'h00);

  // Lowest enabled matching slot wins.
  always_comb begin
    match_any = 1'b0;
    hit_id    = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (en_mask[i] && a_hour[i] == cur_hour && a_min[i] == cur_min) begin
        match_any = 1'b1;
        hit_id    = ID_W'(i);
      end
    end
  end

  assign hit = tick & match_any;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(NUM_ALARMS); i++) begin
        a_hour[i] <= RST_HOUR;
        a_min[i]  <= RST_MIN;
      end
      en_mask  <= '0;
      field    <= FLD_HOUR;
      state    <= ST_IDLE;
      ring_q   <= 1'b0;
      snz_q    <= 1'b0;
      ring_id  <= '0;
      snz_cnt  <= '0;
      ring_cnt <= '0;
      tgt      <= '0;
      sec_q    <= '0;
    end else begin
      sec_q <= cur_sec;
      if (SET_MODE) begin
        state  <= ST_IDLE;
        ring_q <= 1'b0;
        snz_q  <= 1'b0;
        if (p_next) field <= ~field;
        if (sel_ok && (p_up ^ p_down)) begin
          if (field == FLD_HOUR)
            a_hour[SEL] <= p_up ? bcd_inc_wrap(a_hour[SEL], HOUR_MAX)
                                : bcd_dec_wrap(a_hour[SEL], HOUR_MAX);
          else
            a_min[SEL]  <= p_up ? bcd_inc_wrap(a_min[SEL], MIN_MAX)
                                : bcd_dec_wrap(a_min[SEL], MIN_MAX);
        end
        if (sel_ok && p_en) en_mask <= en_mask ^ (NUM_ALARMS'(1) << SEL);
      end else begin
        field <= FLD_HOUR;
        case (state)
          ST_IDLE: begin
            if (hit) begin
              state    <= ST_RING;
              ring_q   <= 1'b1;
              ring_id  <= hit_id;
              snz_cnt  <= '0;
              ring_cnt <= '0;
            end
          end
          ST_RING: begin
            if (p_en) begin
              state  <= ST_IDLE;
              ring_q <= 1'b0;
            end else if (p_snz && snz_cnt < 4'(MAX_SNOOZE)) begin
              state   <= ST_SNOOZE;
              ring_q  <= 1'b0;
              snz_q   <= 1'b1;
              tgt     <= bcd_add_minutes(cur_hour, cur_min, 6'(SNOOZE_MIN));
              snz_cnt <= snz_cnt + 4'd1;
            end else if (tick) begin
              if (ring_cnt + 4'd1 == 4'(RING_MIN)) begin
                state  <= ST_IDLE;
                ring_q <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + 4'd1;
              end
            end
          end
          ST_SNOOZE: begin
            if (p_en) begin
              state <= ST_IDLE;
              snz_q <= 1'b0;
            end else if (hit) begin
              state    <= ST_RING;
              ring_q   <= 1'b1;
              snz_q    <= 1'b0;
              ring_id  <= hit_id;
              snz_cnt  <= '0;
              ring_cnt <= '0;
            end else if (tick && {cur_hour, cur_min} == tgt) begin
              state    <= ST_RING;
              ring_q   <= 1'b1;
              snz_q    <= 1'b0;
              ring_cnt <= '0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            ring_q <= 1'b0;
            snz_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign {AHOUR1, AHOUR0} = sel_ok ? a_hour[SEL] : 8'h00;
  assign {AMIN1, AMIN0}   = sel_ok ? a_min[SEL]  : 8'h00;
  assign EN_MASK = en_mask;
  assign FIELD   = field;
  assign RING    = ring_q;
  assign RING_ID = ring_id;
  assign SNOOZED = snz_q;

endmodule

// File: tb/tb_multi_alarm.sv
// Bench for multi_alarm: edit vectors, randomized edits against an integer model,
// and hand sequences for ringing, snooze, timeout, preempt and reset.
module tb_multi_alarm;

  localparam int NA = 4;
  localparam int OP_NEXT = 0, OP_UP = 1, OP_DN = 2, OP_UPDN = 3, OP_EN = 4, OP_SNZ = 5;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       SET_MODE = 1'b0;
  logic [1:0] SEL = '0;
  logic       KEY_NEXT = 1'b0, KEY_UP = 1'b0, KEY_DOWN = 1'b0, KEY_EN = 1'b0, KEY_SNOOZE = 1'b0;
  logic [3:0] HOUR1 = '0, HOUR0 = '0, MIN1 = '0, MIN0 = '0, SEC1 = '0, SEC0 = '0;

  logic [3:0] AHOUR1, AHOUR0, AMIN1, AMIN0;
  logic [3:0] EN_MASK;
  logic       FIELD, RING, SNOOZED;
  logic [1:0] RING_ID;
  logic [3:0] AHOUR1_2, AHOUR0_2, AMIN1_2, AMIN0_2;
  logic [3:0] EN_MASK_2;
  logic       FIELD_2, RING_2, SNOOZED_2;
  logic [1:0] RING_ID_2;

  multi_alarm #(.NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_MIN(1), .MAX_SNOOZE(3)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .SET_MODE(SET_MODE), .SEL(SEL),
    .KEY_NEXT(KEY_NEXT), .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN), .KEY_EN(KEY_EN),
    .KEY_SNOOZE(KEY_SNOOZE),
    .HOUR1(HOUR1), .HOUR0(HOUR0), .MIN1(MIN1), .MIN0(MIN0), .SEC1(SEC1), .SEC0(SEC0),
    .AHOUR1(AHOUR1), .AHOUR0(AHOUR0), .AMIN1(AMIN1), .AMIN0(AMIN0),
    .EN_MASK(EN_MASK), .FIELD(FIELD), .RING(RING), .RING_ID(RING_ID), .SNOOZED(SNOOZED)
  );

  // Same stimulus, two-minute ring timeout.
  multi_alarm #(.NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_MIN(2), .MAX_SNOOZE(3)) u_dut2 (
    .CLK(CLK), .RSTN(RSTN), .SET_MODE(SET_MODE), .SEL(SEL),
    .KEY_NEXT(KEY_NEXT), .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN), .KEY_EN(KEY_EN),
    .KEY_SNOOZE(KEY_SNOOZE),
    .HOUR1(HOUR1), .HOUR0(HOUR0), .MIN1(MIN1), .MIN0(MIN0), .SEC1(SEC1), .SEC0(SEC0),
    .AHOUR1(AHOUR1_2), .AHOUR0(AHOUR0_2), .AMIN1(AMIN1_2), .AMIN0(AMIN0_2),
    .EN_MASK(EN_MASK_2), .FIELD(FIELD_2), .RING(RING_2), .RING_ID(RING_ID_2),
    .SNOOZED(SNOOZED_2)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         op;
    int         sel;
    logic [7:0] hh;
    logic [7:0] mm;
    logic       fld;
    logic [3:0] en;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input int op);
    KEY_NEXT   = (op == OP_NEXT);
    KEY_UP     = (op == OP_UP) || (op == OP_UPDN);
    KEY_DOWN   = (op == OP_DN) || (op == OP_UPDN);
    KEY_EN     = (op == OP_EN);
    KEY_SNOOZE = (op == OP_SNZ);
    step(1);
    KEY_NEXT = 0; KEY_UP = 0; KEY_DOWN = 0; KEY_EN = 0; KEY_SNOOZE = 0;
    step(3);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    step(2);
    RSTN = 1'b1;
    step(1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    HOUR1 = 4'(h / 10); HOUR0 = 4'(h % 10);
    MIN1  = 4'(m / 10); MIN0  = 4'(m % 10);
    SEC1  = 4'(s / 10); SEC0  = 4'(s % 10);
  endtask

  // Hold :59 of the current minute, then jump to h:m:00 and pass the tick edge.
  task automatic goto_min(input int h, input int m);
    SEC1 = 4'd5; SEC0 = 4'd9;
    step(2);
    set_time(h, m, 0);
    step(1);
  endtask

  // Programs a freshly reset slot (01:00, cursor on hour) and enables it.
  task automatic set_alarm(input int slot, input int h, input int m);
    int up;
    SEL = 2'(slot);
    up = (h + 23) % 24;
    if (up <= 12) repeat (up) press(OP_UP); else repeat (24 - up) press(OP_DN);
    press(OP_NEXT);
    if (m <= 30) repeat (m) press(OP_UP); else repeat (60 - m) press(OP_DN);
    press(OP_NEXT);
    press(OP_EN);
    chk("set_alarm_hhmm", int'({AHOUR1, AHOUR0, AMIN1, AMIN0}), bcd(h) * 256 + bcd(m));
  endtask

  int mh[NA];
  int mm[NA];
  logic [3:0] men;
  int mf;
  int s, op, bad;

  initial begin
    // Reset state
    RSTN = 1'b0;
    step(3);
    RSTN = 1'b1;
    step(1);
    for (int i = 0; i < NA; i++) begin
      SEL = 2'(i);
      #1;
      chk("rst_ahour", int'({AHOUR1, AHOUR0}), 'h01);
      chk("rst_amin", int'({AMIN1, AMIN0}), 'h00);
    end
    chk("rst_en_mask", int'(EN_MASK), 0);
    chk("rst_ring", int'(RING), 0);
    chk("rst_snoozed", int'(SNOOZED), 0);
    chk("rst_field", int'(FIELD), 0);
    chk("rst_ring_id", int'(RING_ID), 0);

    // Edit vectors
    tbl.push_back('{OP_UP,   2, 8'h02, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_UP,   2, 8'h03, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_UP,   2, 8'h04, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_DN,   2, 8'h03, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_DN,   2, 8'h02, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_DN,   2, 8'h01, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_DN,   2, 8'h00, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_DN,   2, 8'h23, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_UP,   2, 8'h00, 8'h00, 1'b0, 4'b0000});
    tbl.push_back('{OP_NEXT, 2, 8'h00, 8'h00, 1'b1, 4'b0000});
    tbl.push_back('{OP_DN,   2, 8'h00, 8'h59, 1'b1, 4'b0000});
    tbl.push_back('{OP_UPDN, 2, 8'h00, 8'h59, 1'b1, 4'b0000});
    tbl.push_back('{OP_UP,   2, 8'h00, 8'h00, 1'b1, 4'b0000});
    tbl.push_back('{OP_UP,   1, 8'h01, 8'h01, 1'b1, 4'b0000});
    tbl.push_back('{OP_EN,   2, 8'h00, 8'h00, 1'b1, 4'b0100});
    tbl.push_back('{OP_EN,   1, 8'h01, 8'h01, 1'b1, 4'b0110});
    tbl.push_back('{OP_NEXT, 2, 8'h00, 8'h00, 1'b0, 4'b0110});
    SET_MODE = 1'b1;
    foreach (tbl[k]) begin
      SEL = 2'(tbl[k].sel);
      press(tbl[k].op);
      chk($sformatf("vec%0d_ahour", k), int'({AHOUR1, AHOUR0}), int'(tbl[k].hh));
      chk($sformatf("vec%0d_amin", k), int'({AMIN1, AMIN0}), int'(tbl[k].mm));
      chk($sformatf("vec%0d_field", k), int'(FIELD), int'(tbl[k].fld));
      chk($sformatf("vec%0d_en", k), int'(EN_MASK), int'(tbl[k].en));
    end
    SET_MODE = 1'b0;
    step(1);
    chk("field_clears_on_run", int'(FIELD), 0);

    // Randomized edits against an integer time model
    do_reset();
    SET_MODE = 1'b1;
    for (int i = 0; i < NA; i++) begin mh[i] = 1; mm[i] = 0; end
    men = '0;
    mf = 0;
    for (int k = 0; k < 40; k++) begin
      s  = int'($urandom_range(0, NA - 1));
      op = int'($urandom_range(0, 4));
      SEL = 2'(s);
      press(op);
      case (op)
        OP_NEXT: mf = 1 - mf;
        OP_UP:   if (mf == 0) mh[s] = (mh[s] + 1) % 24; else mm[s] = (mm[s] + 1) % 60;
        OP_DN:   if (mf == 0) mh[s] = (mh[s] + 23) % 24; else mm[s] = (mm[s] + 59) % 60;
        OP_EN:   men[s] = ~men[s];
        default: ;
      endcase
      chk("rnd_ahour", int'({AHOUR1, AHOUR0}), bcd(mh[s]));
      chk("rnd_amin", int'({AMIN1, AMIN0}), bcd(mm[s]));
      chk("rnd_field", int'(FIELD), mf);
      chk("rnd_en", int'(EN_MASK), int'(men));
    end
    SET_MODE = 1'b0;

    // Two slots at 07:30: lowest index rings once, held :00 does not retrigger
    do_reset();
    SET_MODE = 1'b1;
    set_alarm(1, 7, 30);
    set_alarm(3, 7, 30);
    chk("a_en_mask", int'(EN_MASK), 'b1010);
    SET_MODE = 1'b0;
    set_time(7, 29, 59);
    step(2);
    set_time(7, 30, 0);
    chk("a_ring_before_edge", int'(RING), 0);
    step(1);
    chk("a_ring", int'(RING), 1);
    chk("a_ring_id", int'(RING_ID), 1);
    chk("a_ring2", int'(RING_2), 1);
    bad = 0;
    repeat (100) begin
      step(1);
      if (RING !== 1'b1 || RING_ID !== 2'd1 || SNOOZED !== 1'b0) bad++;
    end
    chk("a_hold_steady", bad, 0);
    goto_min(7, 31);
    chk("a_timeout_ring1", int'(RING), 0);
    chk("a_timeout_ring2_still", int'(RING_2), 1);
    goto_min(7, 32);
    chk("a_timeout_ring2_off", int'(RING_2), 0);
    chk("a_idle_ring", int'(RING), 0);

    // Snooze across midnight
    do_reset();
    SET_MODE = 1'b1;
    set_alarm(0, 23, 58);
    SET_MODE = 1'b0;
    set_time(23, 57, 59);
    step(2);
    set_time(23, 58, 0);
    step(1);
    chk("b_ring", int'(RING), 1);
    chk("b_ring_id", int'(RING_ID), 0);
    press(OP_SNZ);
    chk("b_snz_ring", int'(RING), 0);
    chk("b_snoozed", int'(SNOOZED), 1);
    goto_min(23, 59);
    chk("b_snoozed_2359", int'(SNOOZED), 1);
    goto_min(0, 2);
    chk("b_no_ring_0002", int'(RING), 0);
    goto_min(0, 3);
    chk("b_ring_0003", int'(RING), 1);
    chk("b_ring_id_kept", int'(RING_ID), 0);
    chk("b_snoozed_clr", int'(SNOOZED), 0);

    // Snooze limit: two more snoozes, fourth press ignored, then timeout
    press(OP_SNZ);
    chk("c_snoozed2", int'(SNOOZED), 1);
    goto_min(0, 8);
    chk("c_ring_0008", int'(RING), 1);
    press(OP_SNZ);
    goto_min(0, 13);
    chk("c_ring_0013", int'(RING), 1);
    press(OP_SNZ);
    chk("c_4th_ignored_ring", int'(RING), 1);
    chk("c_4th_ignored_snz", int'(SNOOZED), 0);
    goto_min(0, 14);
    chk("c_timeout_ring1", int'(RING), 0);
    chk("c_ring2_1st_tick", int'(RING_2), 1);
    goto_min(0, 15);
    chk("c_ring2_2nd_tick", int'(RING_2), 0);

    // Preempt during snooze, dismiss, then reset mid-ring
    do_reset();
    SET_MODE = 1'b1;
    set_alarm(0, 10, 0);
    set_alarm(2, 10, 3);
    SET_MODE = 1'b0;
    set_time(9, 59, 59);
    step(2);
    set_time(10, 0, 0);
    step(1);
    chk("d_ring_id0", int'(RING_ID), 0);
    press(OP_SNZ);
    chk("d_snoozed", int'(SNOOZED), 1);
    goto_min(10, 3);
    chk("d_preempt_ring", int'(RING), 1);
    chk("d_preempt_id", int'(RING_ID), 2);
    chk("d_preempt_snz", int'(SNOOZED), 0);
    press(OP_EN);
    chk("d_dismiss_ring", int'(RING), 0);
    chk("d_dismiss_snz", int'(SNOOZED), 0);
    set_time(10, 2, 59);
    step(2);
    set_time(10, 3, 0);
    step(1);
    chk("d_ring_again", int'(RING), 1);
    RSTN = 1'b0;
    step(1);
    chk("e_rst_ring", int'(RING), 0);
    chk("e_rst_snz", int'(SNOOZED), 0);
    chk("e_rst_id", int'(RING_ID), 0);
    chk("e_rst_en", int'(EN_MASK), 0);
    for (int i = 0; i < NA; i++) begin
      SEL = 2'(i);
      #1;
      chk("e_rst_slot", int'({AHOUR1, AHOUR0, AMIN1, AMIN0}), 'h0100);
    end
    RSTN = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_alarm.md
Name: multi_alarm

Overview:
- Parametrised successor to the single-alarm block.
- Holds NUM_ALARMS independent HH:MM alarms, each with its own enable bit, all edited through one shared key set.
- Adds snooze with a retry limit, ring auto-timeout and multi-alarm priority.
- Sits beside the timekeeping counter: it reads the BCD time and drives the buzzer/LED enable and the alarm-edit display mux.

Parameters:
- NUM_ALARMS, 4: number of alarm slots (2..8).
- SNOOZE_MIN, 5: snooze delay in minutes (1..59).
- RING_MIN, 1: minutes of ringing before auto-dismiss (1..15).
- MAX_SNOOZE, 3: snoozes allowed per ring event before KEY_SNOOZE is ignored.

Ports:
- CLK  in  1  system clock.
- RSTN  in  1  reset, synchronous, active-low.
- SET_MODE  in  1  1 = edit alarms, 0 = run.
- SEL  in  $clog2(NUM_ALARMS)  alarm slot being edited/displayed.
- KEY_NEXT  in  1  level; press toggles edited field (hour/min).
- KEY_UP  in  1  level; press increments field.
- KEY_DOWN  in  1  level; press decrements field.
- KEY_EN  in  1  level; set mode: toggle enable of SEL slot; run mode: dismiss.
- KEY_SNOOZE  in  1  level; run mode snooze.
- HOUR1, HOUR0, MIN1, MIN0, SEC1, SEC0  in  4 each  current BCD time.
- AHOUR1, AHOUR0, AMIN1, AMIN0  out  4 each  stored alarm of slot SEL (combinational mux).
- EN_MASK  out  NUM_ALARMS  enable bit per slot.
- FIELD  out  1  0 = hour, 1 = min (edit cursor).
- RING  out  1  alarm sounding.
- RING_ID  out  $clog2(NUM_ALARMS)  slot that caused the current ring or snooze.
- SNOOZED  out  1  snooze pending.

Behaviour:
- Reset (RSTN low at a CLK edge):
  - All slots 01:00, EN_MASK = 0, FIELD = 0.
  - RING = 0, RING_ID = 0, SNOOZED = 0, state IDLE, snooze/ring counters 0.
  - Key synchronisers cleared.
- Reset asserted mid-ring or mid-snooze clears everything on that edge.
- Keys: each key is 2-FF synchronised, then rising-edge detected into a 1-cycle press.
  - Key high before edge t0 → press acted on at edge t2.
  - Holding a key gives exactly one press.
- Set mode (SET_MODE = 1):
  - RING = 0, SNOOZED = 0, state forced to IDLE.
  - KEY_NEXT toggles FIELD. FIELD returns to 0 whenever SET_MODE falls.
  - KEY_UP on hour: 23→00. KEY_DOWN on hour: 00→23. BCD digits carry and borrow at 9/0.
  - Minutes wrap 59→00 and 00→59. Hour does not change on a minute wrap.
  - KEY_UP and KEY_DOWN pressed on the same cycle: no change.
  - KEY_EN toggles EN_MASK[SEL].
  - SEL changes take effect immediately; no pending edit is carried across slots.
- Minute tick: {SEC1,SEC0} registered each cycle. TICK = 1 on the cycle where current == 00 and the registered value != 00. This fires exactly once per minute, even if the time inputs hold at :00 for many cycles.
- Match: slot i matches when EN_MASK[i] = 1, alarm HH:MM == current HH:MM, and TICK = 1. If several slots match, the lowest index wins.
- Run-mode FSM, all transitions registered (RING changes on the edge after the TICK cycle):
  - IDLE → RING on match. Latch RING_ID, clear snooze count and ring-minute count.
  - RING:
    - KEY_EN → IDLE.
    - KEY_SNOOZE with snooze count < MAX_SNOOZE → SNOOZE. Target = current HH:MM + SNOOZE_MIN with BCD carry; 23:58 + 5 → 00:03. Snooze count increments.
    - KEY_SNOOZE with count == MAX_SNOOZE: ignored.
    - Each TICK increments the ring-minute count; reaching RING_MIN → IDLE.
    - New matches are ignored while ringing.
    - KEY_EN and KEY_SNOOZE on the same cycle: dismiss wins.
  - SNOOZE (SNOOZED = 1, RING = 0):
    - TICK with HH:MM == target → RING, same RING_ID, ring-minute count cleared.
    - KEY_EN → IDLE (cancel).
    - A match from any enabled slot preempts → RING with the new RING_ID, snooze count cleared.
- Disabling the ringing slot in set mode has no extra effect, because set mode already forces IDLE.

Decomposition:
- Package alarm_pkg:
  - State enum {IDLE, RING, SNOOZE}.
  - Field constants FLD_HOUR = 0, FLD_MIN = 1.
  - BCD limits HOUR_MAX = 8'h23, MIN_MAX = 8'h59, reset alarm 8'h01 / 8'h00.
  - Functions bcd_inc_wrap, bcd_dec_wrap, and bcd_add_minutes (HH:MM + n with day wrap).
- Sub-module key_edge (2-FF sync + rising-edge pulse, synchronous active-low reset), instantiated once per key.

Test Plan:
- Reset → AHOUR = 01, AMIN = 00 for every SEL; EN_MASK = 0; RING = 0; SNOOZED = 0.
- Set mode, SEL = 2, field hour:
  - 3 UP presses from 01 → 04.
  - DOWN at 00 → 23; UP at 23 → 00.
  - NEXT, then DOWN at min 00 → 59 with hour unchanged.
  - UP + DOWN on the same cycle → unchanged.
- Slots 1 and 3 enabled, both 07:30; time steps 07:29:59 → 07:30:00 and holds there 100 cycles → RING = 1 from the next edge with RING_ID = 1, asserted once; no retrigger while 07:30:00 holds.
- Snooze wrap: ring at 23:58, SNOOZE → SNOOZED = 1, RING = 0; time reaches 00:03:00 → RING = 1, RING_ID unchanged.
- Snooze limit, MAX_SNOOZE = 3: fourth snooze press ignored, RING stays 1. With RING_MIN = 1, the next TICK → RING = 0, state IDLE. With RING_MIN = 2, RING stays 1 for exactly two TICKs.
- Preempt: during SNOOZE from slot 0, slot 2 matches → RING = 1, RING_ID = 2, SNOOZED = 0.
- Reset mid-operation: RSTN low during RING → RING = 0 and all slots restored to reset values on the same edge.
